// File: rtl/fsm_dual_edge_gen_pkg.sv
// Shared definitions for the dual-edge generator: FSM state encoding and default widths.
package fsm_dual_edge_gen_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned GAP_W_DEF = 8;

    // Encodings are kept fixed because the detector-side bench relies on them.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/fsm_dual_edge_gen_if.sv
// Command/handshake and line outputs of the dual-edge generator.
interface fsm_dual_edge_gen_if
    import fsm_dual_edge_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned GAP_W = GAP_W_DEF
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_edges;
    logic [GAP_W-1:0] cmd_gap;
    logic             abort;
    logic             dout;
    logic             edge_strobe;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_edges, cmd_gap, abort,
        input  cmd_ready, dout, edge_strobe, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_edges, cmd_gap, abort,
        output cmd_ready, dout, edge_strobe, busy, done
    );

endinterface

// File: rtl/fsm_dual_edge_gap_cnt.sv
// Loadable down-counter with zero flag; saturates at zero rather than wrapping.
module fsm_dual_edge_gap_cnt #(
    parameter int unsigned GAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [GAP_W-1:0] load_val,
    output logic             zero
);

    logic [GAP_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/fsm_dual_edge_gen.sv
// Dual-edge transmitter: emits a programmed number of dout transitions spaced gap+1 cycles apart.
module fsm_dual_edge_gen
    import fsm_dual_edge_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned GAP_W = GAP_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    fsm_dual_edge_gen_if.slave    bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] edges_left_q, edges_left_d;
    logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
    logic             dout_q, dout_d;
    logic             strobe_q, strobe_d;

    logic             gc_load;
    logic             gc_dec;
    logic [GAP_W-1:0] gc_val;
    logic             gc_zero;

    fsm_dual_edge_gap_cnt #(
        .GAP_W (GAP_W)
    ) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gc_load),
        .dec      (gc_dec),
        .load_val (gc_val),
        .zero     (gc_zero)
    );

    always_comb begin
        state_d      = state_q;
        edges_left_d = edges_left_q;
        gap_lat_d    = gap_lat_q;
        dout_d       = dout_q;
        strobe_d     = 1'b0;
        gc_load      = 1'b0;
        gc_dec       = 1'b0;
        gc_val       = gap_lat_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    gc_load      = 1'b1;
                    gc_val       = bus.cmd_gap;
                    gap_lat_d    = bus.cmd_gap;
                    edges_left_d = bus.cmd_edges;
                    state_d      = (bus.cmd_edges == '0) ? S_FIN : S_GAP;
                end
            end
            S_GAP: begin
                // Abort wins over a toggle due in the same cycle.
                if (bus.abort) begin
                    state_d = S_FIN;
                end else if (gc_zero) begin
                    dout_d   = ~dout_q;
                    strobe_d = 1'b1;
                    gc_load  = 1'b1;
                    if (edges_left_q != '0) begin
                        edges_left_d = edges_left_q - CNT_W'(1);
                    end
                    if (edges_left_q == CNT_W'(1)) begin
                        state_d = S_FIN;
                    end
                end else begin
                    gc_dec = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            edges_left_q <= '0;
            gap_lat_q    <= '0;
            dout_q       <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            edges_left_q <= edges_left_d;
            gap_lat_q    <= gap_lat_d;
            dout_q       <= dout_d;
            strobe_q     <= strobe_d;
        end
    end

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_FIN);
    assign bus.dout        = dout_q;
    assign bus.edge_strobe = strobe_q;

endmodule

// File: tb/tb_fsm_dual_edge_gen.sv
// Self-checking bench for fsm_dual_edge_gen against an edge-timeline reference model.
module tb_fsm_dual_edge_gen;

    logic clk;
    logic rst;

    fsm_dual_edge_gen_if #(.CNT_W(8), .GAP_W(8)) bus ();

    fsm_dual_edge_gen #(.CNT_W(8), .GAP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Loopback detector: counts level changes on dout and done pulses.
    int unsigned det_cnt  = 0;
    int unsigned done_cnt = 0;
    logic        prev_dout = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.dout !== prev_dout) det_cnt++;
            if (bus.done === 1'b1) done_cnt++;
        end
        prev_dout = bus.dout;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Model: edge k is visible at offset gap+2+k*(gap+1) from the accept cycle.
    // An abort at offset ta suppresses every edge after ta and puts done at ta+1.
    task automatic run_cmd(input int unsigned edges, input int unsigned gap,
                           input int unsigned abort_at, input bit noise,
                           output int unsigned generated);
        int unsigned done_t, done_eff, lim, n_vis;
        logic init, exp_dout, exp_strobe, exp_done, exp_busy;
        bit ok;
        ok = 1'b0;
        generated = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ready_wait got=%b exp=1", bus.cmd_ready);
            return;
        end
        init          = bus.dout;
        bus.cmd_valid = 1'b1;
        bus.cmd_edges = edges[7:0];
        bus.cmd_gap   = gap[7:0];
        done_t = (edges == 0) ? 1 : 1 + edges * (gap + 1);
        if (edges != 0 && abort_at >= 1 && abort_at < done_t) begin
            done_eff = abort_at + 1;
            lim      = abort_at;
        end else begin
            done_eff = done_t;
            lim      = done_t;
        end
        for (int unsigned t = 1; t <= done_eff + 1; t++) begin
            @(negedge clk);
            n_vis      = 0;
            exp_strobe = 1'b0;
            for (int unsigned k = 0; k < edges; k++) begin
                if (gap + 2 + k * (gap + 1) <= t && gap + 2 + k * (gap + 1) <= lim) n_vis++;
                if (gap + 2 + k * (gap + 1) == t && t <= lim) exp_strobe = 1'b1;
            end
            exp_dout = init ^ n_vis[0];
            exp_done = (t == done_eff);
            exp_busy = (t <= done_eff);
            checks++;
            if (bus.dout !== exp_dout) begin
                errors++;
                $display("FAIL dout e=%0d g=%0d t=%0d got=%b exp=%b", edges, gap, t, bus.dout, exp_dout);
            end
            checks++;
            if (bus.edge_strobe !== exp_strobe) begin
                errors++;
                $display("FAIL edge_strobe e=%0d g=%0d t=%0d got=%b exp=%b", edges, gap, t, bus.edge_strobe, exp_strobe);
            end
            checks++;
            if (bus.done !== exp_done) begin
                errors++;
                $display("FAIL done e=%0d g=%0d t=%0d got=%b exp=%b", edges, gap, t, bus.done, exp_done);
            end
            checks++;
            if (bus.busy !== exp_busy || bus.cmd_ready !== !exp_busy) begin
                errors++;
                $display("FAIL busy_ready e=%0d g=%0d t=%0d got=%b/%b exp=%b/%b", edges, gap, t,
                         bus.busy, bus.cmd_ready, exp_busy, !exp_busy);
            end
            bus.cmd_valid = (t < done_eff) ? (noise & $urandom_range(0, 1)) : 1'b0;
            bus.cmd_edges = 8'($urandom);
            bus.cmd_gap   = 8'($urandom);
            bus.abort     = (t == abort_at);
            generated     = n_vis;
        end
        bus.abort     = 1'b0;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.dout, bus.cmd_ready, bus.busy, bus.done, bus.edge_strobe} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=01000",
                     {bus.dout, bus.cmd_ready, bus.busy, bus.done, bus.edge_strobe});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.dout, bus.cmd_ready, bus.busy, bus.done, bus.edge_strobe} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_release got=%b exp=01000",
                     {bus.dout, bus.cmd_ready, bus.busy, bus.done, bus.edge_strobe});
        end
    endtask

    task automatic test_basic();
        int unsigned g;
        run_cmd(4, 2, 0, 1'b1, g);
        checks++;
        if (g != 4) begin
            errors++;
            $display("FAIL basic_edges got=%0d exp=4", g);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned g;
        run_cmd(3, 0, 0, 1'b0, g);
        checks++;
        if (bus.dout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_level got=%b exp=1", bus.dout);
        end
        run_cmd(1, 0, 0, 1'b0, g);
        checks++;
        if (bus.dout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_return got=%b exp=0", bus.dout);
        end
    endtask

    task automatic test_zero_edges();
        int unsigned g;
        run_cmd(0, 7, 1, 1'b1, g);
        checks++;
        if (g != 0) begin
            errors++;
            $display("FAIL zero_edges got=%0d exp=0", g);
        end
    endtask

    task automatic test_abort();
        int unsigned g;
        run_cmd(10, 5, 14, 1'b1, g);
        checks++;
        if (g != 2 || bus.dout !== 1'b0) begin
            errors++;
            $display("FAIL abort got=%0d/%b exp=2/0", g, bus.dout);
        end
        // abort landing on the FIN cycle must not change anything
        run_cmd(2, 1, 5, 1'b0, g);
    endtask

    task automatic test_reset_mid();
        int unsigned waited;
        waited = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_edges = 8'd10;
        bus.cmd_gap   = 8'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.dout !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset got=%b exp=1", bus.dout);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.dout, bus.cmd_ready, bus.busy, bus.done, bus.edge_strobe} !== 5'b01000) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=01000",
                     {bus.dout, bus.cmd_ready, bus.busy, bus.done, bus.edge_strobe});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.dout, bus.cmd_ready, bus.busy, bus.done, bus.edge_strobe} !== 5'b01000) begin
            errors++;
            $display("FAIL mid_after got=%b exp=01000",
                     {bus.dout, bus.cmd_ready, bus.busy, bus.done, bus.edge_strobe});
        end
    endtask

    task automatic test_random();
        int unsigned det0, done0, sum, g, e, gp, ab, dt;
        det0  = det_cnt;
        done0 = done_cnt;
        sum   = 0;
        for (int n = 0; n < 200; n++) begin
            e  = $urandom_range(0, 20);
            gp = $urandom_range(0, 5);
            dt = (e == 0) ? 1 : 1 + e * (gp + 1);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, dt) : 0;
            run_cmd(e, gp, ab, 1'b1, g);
            sum += g;
        end
        @(negedge clk);
        checks++;
        if (det_cnt - det0 != sum) begin
            errors++;
            $display("FAIL loopback_edges got=%0d exp=%0d", det_cnt - det0, sum);
        end
        checks++;
        if (done_cnt - done0 != 200) begin
            errors++;
            $display("FAIL done_pulses got=%0d exp=200", done_cnt - done0);
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_edges = '0;
        bus.cmd_gap   = '0;
        bus.abort     = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_edges();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
